cnn_layer_seq: RTL
==================

# cnn_layer_seq

Frame sequencer for the first convolution stage. Accepts a raster-order pixel stream, loads it into the Conv2D_1 image buffer, then enables the layer and detects completion from the layer's read-enable feedback. It also guards against a hung layer with a timeout and reports per-frame status. It sits between the host/DMA pixel source and Conv2D_1, and replaces hand-sequenced enable/write control.

## Interface
- IMG_H, 35, image rows
- IMG_W, 35, image columns
- DATA_W, 16, pixel width
- ADDR_W, 16, buffer address width; must satisfy IMG_H*IMG_W <= 2^ADDR_W
- GAP_CYC, 4, idle cycles between the last buffer write and layer_enable
- DRAIN_CYC, 16, cycles after completion before frame_done, so pool writes can finish
- TIMEOUT_CYC, 65535, maximum RUN-state cycles
- EXP_OUT, 1089, expected pool-bus writes per frame (33*33 for a 3x3 kernel)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid & s_ready
- s_data  in  DATA_W  pixel value
- abort  in  1  synchronous abort, any state
- clear_err  in  1  clears sticky error flags
- img_data_wr_en  out  1  buffer write strobe to Conv2D_1
- img_data_addr  out  ADDR_W  buffer write address
- img_data_in  out  DATA_W  buffer write data
- layer_enable  out  1  Conv2D_1 enable
- img_data_rd_en  in  1  Conv2D_1 busy/read feedback; its falling edge means done
- pool_wr_en  in  1  Conv2D_1 to pool_1 write strobe (monitor only)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0
- err_timeout  out  1  sticky
- err_outcnt  out  1  sticky; only when CNN_SEQ_OUTCNT_EN is defined, otherwise tied 0

## Operation
- States: IDLE → LOAD → GAP → RUN → DRAIN → DONE → IDLE; ERR is entered from RUN.
- **IDLE**
  - s_ready=1.
  - The first accepted pixel is written to address 0 and the state moves to LOAD.
- **LOAD**
  - s_ready=1.
  - Each accepted pixel k is written to address k, raster order, k in 0..IMG_H*IMG_W-1.
  - Stalls (s_valid=0) insert write bubbles; the address does not advance.
  - After pixel IMG_H*IMG_W-1: s_ready=0 and the state moves to GAP.
- **GAP**: counts GAP_CYC cycles, then moves to RUN. s_ready=0 in all states except IDLE and LOAD.
- **RUN**
  - layer_enable=1.
  - seen_hi is set when img_data_rd_en=1 is sampled.
  - Done is img_data_rd_en_q & ~img_data_rd_en & seen_hi. Done moves the state to DRAIN.
  - Timeout counter reaching TIMEOUT_CYC: set err_timeout and move to ERR.
- **DRAIN**
  - layer_enable=0.
  - Counts DRAIN_CYC cycles, then moves to DONE.
- **DONE**: frame_done=1 for one cycle, frame_cnt+1, then IDLE.
- **ERR**
  - layer_enable=0.
  - Stays in ERR until clear_err=1, then IDLE with err_timeout cleared.
- **abort**
  - Returns to IDLE from any state.
  - Clears the address counter, seen_hi and the counters; no frame_done.
  - Error flags are preserved.
  - abort takes priority over done, timeout and the final pixel when they occur in the same cycle.
- **clear_err outside ERR**: clears the sticky flags only; no state change.

## Timing
- **Reset values**: all outputs are 0, except s_ready=1 (IDLE).
- **Write latency**: the pixel accepted at edge n produces img_data_wr_en/addr/data valid from edge n+1 for one cycle (registered).
- **Back-to-back accepts**: write one pixel per cycle.
- **GAP timing**: the last write strobe is followed by exactly GAP_CYC cycles with both img_data_wr_en and layer_enable low.
- **layer_enable**: registered; rises on the edge that enters RUN and falls on the edge after the done detect.
- **Completion latency**: frame_done asserts DRAIN_CYC+1 cycles after layer_enable falls.
- **Ignored pulses**: an img_data_rd_en falling edge without a prior high in the current RUN is ignored.
- **Mid-operation reset**: rst_n low asynchronously drops every output within the same cycle.

## Configuration
- **CNN_SEQ_OUTCNT_EN defined**:
  - A 16-bit counter counts pool_wr_en during RUN and DRAIN.
  - In DONE, a count != EXP_OUT sets err_outcnt (sticky). frame_done still pulses.
  - The counter clears at frame start.
- **Not defined**: no counter is built and err_outcnt is constant 0.

## Structure
- **Shared package cnn_seq_pkg**:
  - State enum: IDLE, LOAD, GAP, RUN, DRAIN, DONE, ERR.
  - Default parameter constants.
  - localparam for the pixel count N = IMG_H*IMG_W, shared with the pool stage.
- **Sub-module cnn_seq_addr_cnt**:
  - Raster address counter with clear, enable and last flag (count == N-1).
  - Reused by the pool_1 loader.

## Test plan
- **Single frame**: 1225 pixels on continuous s_valid with data = k+1.
  - Expect addresses 0..1224 with matching data, s_ready low after the last pixel, exactly 4 idle cycles, then layer_enable.
  - Model rd_en high 10 cycles after enable and low 2000 cycles later; expect frame_done 17 cycles after layer_enable falls and frame_cnt=1.
- **Stalled input**: s_valid deasserted 1 cycle in every 3 → still exactly 1225 writes, no address skips or repeats.
- **Timeout**: TIMEOUT_CYC=100 with rd_en held low.
  - Expect err_timeout at cycle 100 of RUN, layer_enable=0, s_ready=0 until clear_err.
- **Abort**: abort at pixel 600 → IDLE next cycle; a fresh frame restarts at address 0 and frame_cnt is unchanged. Then abort asserted in the same cycle as the rd_en fall → no frame_done.
- **Output count (macro on)**:
  - 1089 pool_wr_en pulses → err_outcnt=0.
  - 1088 pulses → err_outcnt=1, frame_done still pulses.
- **Reset mid-RUN**: rst_n low → layer_enable, busy and img_data_wr_en are 0 immediately. Two frames back-to-back afterwards → frame_cnt=2.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared state encoding and default geometry for the conv-layer sequencer and pool loader.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_e;

    localparam int DEF_IMG_H       = 35;
    localparam int DEF_IMG_W       = 35;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_DRAIN_CYC   = 16;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int DEF_EXP_OUT     = 1089;
    localparam int PIX_N           = DEF_IMG_H * DEF_IMG_W;

endpackage

// File: rtl/cnn_layer_seq_if.sv
// cnn_layer_seq_if: pixel stream in, Conv2D_1 image-buffer/enable bus out, layer feedback in.
interface cnn_layer_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              img_data_wr_en;
    logic [ADDR_W-1:0] img_data_addr;
    logic [DATA_W-1:0] img_data_in;
    logic              layer_enable;
    logic              img_data_rd_en;
    logic              pool_wr_en;

    modport master (
        input  s_valid, s_data, img_data_rd_en, pool_wr_en,
        output s_ready, img_data_wr_en, img_data_addr, img_data_in, layer_enable
    );

    modport slave (
        output s_valid, s_data, img_data_rd_en, pool_wr_en,
        input  s_ready, img_data_wr_en, img_data_addr, img_data_in, layer_enable
    );
endinterface

// File: rtl/cnn_seq_addr_cnt.sv
// cnn_seq_addr_cnt: raster address counter with clear, enable and last-pixel flag; wraps to 0 after N-1.
module cnn_seq_addr_cnt
    import cnn_seq_pkg::*;
#(
    parameter int N      = PIX_N,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last = addr_q == ADDR_W'(N - 1);
    assign addr = addr_q;

    always_comb addr_d = clr ? '0 : en ? (last ? '0 : addr_q + 1'b1) : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_q <= '0;
        else        addr_q <= addr_d;
    end
endmodule

// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq: loads a raster frame into Conv2D_1, runs the layer, detects completion and guards with a timeout.
// Define CNN_SEQ_OUTCNT_EN to build the pool-write output counter and err_outcnt check.
module cnn_layer_seq
    import cnn_seq_pkg::*;
#(
    parameter int IMG_H       = DEF_IMG_H,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int EXP_OUT     = DEF_EXP_OUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cnn_layer_seq_if.master        bus,
    input  logic                   abort,
    input  logic                   clear_err,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic                   err_timeout,
    output logic                   err_outcnt
);
    localparam int N = IMG_H * IMG_W;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              seen_hi_q, seen_hi_d;
    logic              rd_en_q;
    logic              wr_en_q, wr_en_d;
    logic              layer_en_q, layer_en_d;
    logic              err_tmo_q, err_tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_last;
    logic              accept, done, tmo;

    assign bus.s_ready        = state_q == S_IDLE || state_q == S_LOAD;
    assign bus.img_data_wr_en = wr_en_q;
    assign bus.img_data_addr  = addr_q;
    assign bus.img_data_in    = data_q;
    assign bus.layer_enable   = layer_en_q;
    assign busy               = state_q != S_IDLE;
    assign frame_done         = state_q == S_DONE;
    assign frame_cnt          = frame_cnt_q;
    assign err_timeout        = err_tmo_q;

    assign accept = bus.s_valid && bus.s_ready;
    // A fall only counts once this RUN has seen the layer go busy.
    assign done   = rd_en_q && !bus.img_data_rd_en && seen_hi_q;
    assign tmo    = cnt_q == 16'(TIMEOUT_CYC - 1);

    cnn_seq_addr_cnt #(.N(N), .ADDR_W(ADDR_W)) u_addr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (abort),
        .en   (accept && !abort),
        .addr (pix_addr),
        .last (pix_last)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        seen_hi_d = 1'b0;
        err_tmo_d = err_tmo_q && !clear_err;
        wr_en_d   = accept && !abort;
        addr_d    = accept ? pix_addr : addr_q;
        data_d    = accept ? bus.s_data : data_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = pix_last ? S_GAP : S_LOAD;
            end
            S_LOAD: begin
                cnt_d = '0;
                if (accept && pix_last) state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == 16'(GAP_CYC)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                seen_hi_d = seen_hi_q || bus.img_data_rd_en;
                if (done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d   = S_ERR;
                    err_tmo_d = 1'b1;
                end
            end
            S_DRAIN: state_d = cnt_q == 16'(DRAIN_CYC) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = clear_err ? S_IDLE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            seen_hi_d = 1'b0;
        end
        layer_en_d  = state_d == S_RUN;
        frame_cnt_d = frame_cnt_q + 16'(state_q == S_DRAIN && state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            seen_hi_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            layer_en_q  <= 1'b0;
            err_tmo_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            seen_hi_q   <= seen_hi_d;
            rd_en_q     <= bus.img_data_rd_en;
            wr_en_q     <= wr_en_d;
            layer_en_q  <= layer_en_d;
            err_tmo_q   <= err_tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

`ifdef CNN_SEQ_OUTCNT_EN
    logic [15:0] out_cnt_q, out_cnt_d;
    logic        err_out_q, err_out_d;

    assign err_outcnt = err_out_q;

    always_comb begin
        out_cnt_d = (abort || (state_q == S_IDLE && accept)) ? '0 :
                    out_cnt_q + 16'((state_q == S_RUN || state_q == S_DRAIN) && bus.pool_wr_en);
        err_out_d = (state_q == S_DONE && !abort && out_cnt_q != 16'(EXP_OUT)) ||
                    (err_out_q && !clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
            err_out_q <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            err_out_q <= err_out_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = bus.pool_wr_en ^ (EXP_OUT == 0);
    assign err_outcnt = 1'b0;
`endif
endmodule
